dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped (one-way) write-back, write-allocate data-cache controller for the MEM stage.
- Sits between the EX/MEM pipeline register outputs and the off-chip data memory.
- Produces the memory-stall signal that freezes the MEM/WB pipeline register and all upstream pipeline registers while a miss is serviced.
- Owns the tag/valid/dirty state and the line data, and sequences line write-back and refill.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, line width in bits (32 bytes, 8 words).
- NUM_LINES, 32, number of cache lines; index width = log2(NUM_LINES).
- TAG_W, ADDR_W-5-log2(NUM_LINES), tag width (22 at defaults).

Ports:
- clk_i, input, 1, clock; all state updates on rising edge.
- rst_n_i, input, 1, synchronous active-low reset.
- req_i, input, 1, CPU access request (MemRead | MemWrite).
- we_i, input, 1, 1 = store, 0 = load; qualified by req_i.
- addr_i, input, ADDR_W, byte address; bits [1:0] are ignored.
- wdata_i, input, 32, store data.
- rdata_o, output, 32, load data; valid in the hit cycle.
- stall_o, output, 1, memory stall to the pipeline registers.
- mem_en_o, output, 1, memory request; held until mem_ack_i.
- mem_we_o, output, 1, 1 = line write-back, 0 = line fetch.
- mem_addr_o, output, ADDR_W, line-aligned address; low 5 bits are 0.
- mem_wdata_o, output, LINE_W, write-back line data.
- mem_rdata_i, input, LINE_W, refill line data; valid with mem_ack_i.
- mem_ack_i, input, 1, one-cycle completion pulse.

Behaviour:
- Address split: tag = addr_i[ADDR_W-1 : 5+IDX], index = addr_i[5+IDX-1 : 5], word = addr_i[4:2].
- hit = valid[index] & (tag_q[index] == tag).
- FSM states: IDLE, WRITEBACK, REFILL, UPDATE.
- IDLE:
  - req_i & hit: no stall. Load: rdata_o = selected word, combinational, same cycle. Store: word written and dirty set at the clock edge.
  - req_i & ~hit: stall_o = 1 combinationally in the same cycle. Next state is WRITEBACK if valid & dirty, else REFILL.
- WRITEBACK:
  - mem_en_o = 1, mem_we_o = 1, mem_addr_o = {old tag, index, 5'b0}, mem_wdata_o = old line.
  - On mem_ack_i, go to REFILL.
- REFILL:
  - mem_en_o = 1, mem_we_o = 0, mem_addr_o = {new tag, index, 5'b0}.
  - On mem_ack_i, capture mem_rdata_i, write line and tag, set valid = 1, dirty = 0, go to UPDATE.
- UPDATE:
  - One cycle, stall_o = 1, then IDLE.
  - In IDLE the access re-evaluates as a hit and completes; a store then sets dirty.
- stall_o = 1 in WRITEBACK, REFILL and UPDATE.
- Handshake rules:
  - mem_* outputs are registered and stable while mem_en_o = 1.
  - mem_en_o drops in the cycle after mem_ack_i.
  - mem_ack_i outside WRITEBACK/REFILL is ignored.
- Miss latency with a fixed memory latency L: clean miss = L + 2 stall cycles; dirty miss = 2L + 3 stall cycles.
- req_i/addr_i stay stable while stall_o = 1; the pipeline guarantees this.
- Reset (including mid-miss):
  - State = IDLE; all valid and dirty bits = 0; mem_en_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - stall_o = 0 and rdata_o = 0 when req_i = 0.
  - Line data and tag RAM are not reset.
  - A late mem_ack_i after reset is ignored.
- req_i = 0: no state change and stall_o = 0.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - hit_cnt_o increments on each IDLE hit completion, excluding the post-UPDATE replay.
  - miss_cnt_o increments on each IDLE→WRITEBACK or IDLE→REFILL transition.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - Width constants: ADDR_W, LINE_W, offset width 5, word-select width 3.
  - FSM state enum: IDLE, WRITEBACK, REFILL, UPDATE.
  - Address field-extract functions.
- Sub-module dcache_tag_array:
  - Holds the valid/dirty/tag arrays with synchronous clear.
  - Provides a combinational read port and the hit compare.
- Line data storage and the FSM stay in dcache_ctrl.

Test Plan:
- Reset with req_i = 0 → stall_o = 0, mem_en_o = 0; a load to 0x0000_0040 then misses.
- Cold load from 0x0000_0040 with 3-cycle memory ack → stall_o high 5 cycles; mem_addr_o = 0x40, mem_we_o = 0; rdata_o = word 0 of the refill line.
- Store 0xDEADBEEF to 0x44 (hit) → no stall; a load from 0x44 next cycle returns 0xDEADBEEF.
- Load from 0x0000_0440 (same index, new tag, line dirty):
  - Write-back first with mem_addr_o = 0x40, mem_we_o = 1, mem_wdata_o[63:32] = 0xDEADBEEF.
  - Then refill with mem_addr_o = 0x440.
  - Stall = 2L + 3 cycles.
- Assert rst_n_i = 0 during REFILL while mem_en_o = 1, then pulse mem_ack_i → IDLE, mem_en_o = 0; the line stays invalid, so the next access misses.
- With DCACHE_STATS_EN: the sequence above (reset applied beforehand) → hit_cnt_o = 2, miss_cnt_o = 2.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM state type and address helpers for the data cache.
package dcache_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int OFF_W = 5;
  localparam int WSEL_W = 3;
  localparam int NUM_LINES = 32;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word;
    logic [1:0]        byte_sel;
  } addr_t;
  function automatic addr_t split_addr(input logic [ADDR_W-1:0] a);
    return addr_t'(a);
  endfunction
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] i);
    return {t, i, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_tag_array.sv
// dcache_tag_array: per-line valid/dirty/tag state with combinational lookup and hit compare.
module dcache_tag_array
  import dcache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  input  logic             fill,
  input  logic             mark_dirty,
  output logic             valid,
  output logic             dirty,
  output logic             hit,
  output logic [TAG_W-1:0] old_tag
);
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [NUM_LINES];
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (mark_dirty)
      dirty_q[idx] <= 1'b1;
  // Tags are left unreset; valid alone qualifies them.
  always_ff @(posedge clk)
    if (fill) tag_q[idx] <= tag;
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign old_tag = tag_q[idx];
  assign hit = valid && old_tag == tag;
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back, write-allocate data-cache controller for the MEM stage.
// Define DCACHE_STATS_EN to add hit_cnt_o/miss_cnt_o counters.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);
  state_t state, state_nx;
  addr_t fa;
  logic [TAG_W-1:0] old_tag;
  logic valid, dirty, hit, lookup, miss, ack, fill, replay_q, unused;
  logic [LINE_W-1:0] data_q [NUM_LINES];
  assign fa = split_addr(addr_i);
  assign unused = ^fa.byte_sel;
  assign lookup = state == IDLE && req_i;
  assign miss = lookup && !hit;
  // An ack only counts while a request is outstanding, so stale acks after reset fall away.
  assign ack = mem_ack_i && mem_en_o;
  assign fill = state == REFILL && ack;
  assign stall_o = state != IDLE || miss;
  assign rdata_o = lookup && hit ? data_q[fa.idx][{fa.word, 5'b0} +: 32] : '0;
  dcache_tag_array u_tags (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .idx        (fa.idx),
    .tag        (fa.tag),
    .fill       (fill),
    .mark_dirty (lookup && hit && we_i),
    .valid      (valid),
    .dirty      (dirty),
    .hit        (hit),
    .old_tag    (old_tag)
  );
  always_ff @(posedge clk_i)
    state <= !rst_n_i ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = miss ? (valid && dirty ? WRITEBACK : REFILL) : IDLE;
      WRITEBACK: state_nx = ack ? REFILL : WRITEBACK;
      REFILL:    state_nx = ack ? UPDATE : REFILL;
      default:   state_nx = IDLE;
    endcase
  end
  // Requests are launched from the next state; an ack forces a one-cycle gap before the refill.
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      mem_en_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_en_o <= (state_nx == WRITEBACK || state_nx == REFILL) && !ack;
      mem_we_o <= state_nx == WRITEBACK;
      if (state_nx == WRITEBACK) begin
        mem_addr_o <= line_addr(old_tag, fa.idx);
        mem_wdata_o <= data_q[fa.idx];
      end else if (state_nx == REFILL)
        mem_addr_o <= line_addr(fa.tag, fa.idx);
    end
  always_ff @(posedge clk_i)
    if (fill) data_q[fa.idx] <= mem_rdata_i;
    else if (lookup && hit && we_i) data_q[fa.idx][{fa.word, 5'b0} +: 32] <= wdata_i;
  always_ff @(posedge clk_i)
    replay_q <= rst_n_i && state == UPDATE;
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i)
    if (!rst_n_i) begin
      hit_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (lookup && hit && !replay_q) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (miss) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
`else
  logic unused_replay;
  assign unused_replay = replay_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed plus random accesses against a flat-memory reference and a rule-level cache-state model.
module tb_dcache_ctrl;
  logic clk, rst_n, req, we, mem_en, mem_we, mem_ack, stall;
  logic [31:0] addr, wdata, rdata, mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  int n_cmp = 0, n_err = 0, exp_hit = 0, exp_miss = 0;
  int stalls, wb_seen, rf_seen;
  bit done;
  logic [31:0] rd, wb_addr, rf_addr;
  logic [255:0] wb_data;
  logic [255:0] backing [logic [26:0]];
  logic [31:0] ref_mem [logic [29:0]];
  bit r_valid [32];
  bit r_dirty [32];
  logic [21:0] r_tag [32];

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .stall_o     (stall),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return {2'b0, wa} * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction
  function automatic logic [31:0] ref_word(input logic [29:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction
  function automatic logic [255:0] fetch_line(input logic [26:0] ln);
    logic [255:0] l;
    if (backing.exists(ln)) return backing[ln];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word({ln, w[2:0]});
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run(input logic w, input logic [31:0] a, input logic [31:0] wd, input int lat);
    int en_cnt = 0;
    done = 0; stalls = 0; wb_seen = 0; rf_seen = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      req = 1; we = w; addr = a; wdata = wd; mem_ack = 0;
      if (mem_en) begin
        en_cnt++;
        if (en_cnt == lat) begin
          en_cnt = 0;
          mem_ack = 1;
          if (mem_we) begin
            wb_seen++; wb_addr = mem_addr; wb_data = mem_wdata;
            backing[mem_addr[31:5]] = mem_wdata;
          end else begin
            rf_seen++; rf_addr = mem_addr;
            mem_rdata = fetch_line(mem_addr[31:5]);
          end
        end
      end
      #1;
      if (stall) stalls++;
      else begin done = 1; rd = rdata; end
    end
  endtask

  task automatic op(input string nm, input logic w, input logic [31:0] a, input logic [31:0] wd, input int lat);
    int i = int'(a[9:5]);
    logic [21:0] t = a[31:10];
    bit h = r_valid[i] && r_tag[i] == t;
    bit d = !h && r_valid[i] && r_dirty[i];
    logic [31:0] exp_rd = ref_word(a[31:2]);
    run(w, a, wd, lat);
    chk({nm, "/done"}, done, 1);
    chk({nm, "/stalls"}, stalls, h ? 0 : d ? 2*lat + 3 : lat + 2);
    chk({nm, "/wb_count"}, wb_seen, d);
    chk({nm, "/rf_count"}, rf_seen, !h);
    if (d) chk({nm, "/wb_addr"}, wb_addr, {r_tag[i], a[9:5], 5'b0});
    if (!h) chk({nm, "/rf_addr"}, rf_addr, {a[31:5], 5'b0});
    if (!w) chk({nm, "/rdata"}, rd, exp_rd);
    else ref_mem[a[31:2]] = wd;
    if (h) exp_hit++;
    else begin
      exp_miss++;
      r_valid[i] = 1; r_tag[i] = t; r_dirty[i] = 0;
    end
    if (w) r_dirty[i] = 1;
  endtask

  task automatic idle_chk(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      req = 0; mem_ack = 0;
      #1;
      chk("idle_stall", stall, 0);
      chk("idle_rdata", rdata, 0);
      chk("idle_mem_en", mem_en, 0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin r_valid[i] = 0; r_dirty[i] = 0; end
    exp_hit = 0; exp_miss = 0;
  endtask

  initial begin
    logic [31:0] ra;
    rst_n = 0; req = 0; we = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    rst_n = 1;
    idle_chk(2);
    op("cold_load_40", 0, 32'h40, 0, 3);
    op("store_44", 1, 32'h44, 32'hDEADBEEF, 3);
    op("load_44", 0, 32'h44, 0, 3);
    chk("load_44_value", rd, 32'hDEADBEEF);
    op("dirty_load_440", 0, 32'h440, 0, 3);
    chk("wb_word1", wb_data[63:32], 32'hDEADBEEF);
`ifdef DCACHE_STATS_EN
    chk("seq_hit_cnt", hit_cnt, 2);
    chk("seq_miss_cnt", miss_cnt, 2);
`endif
    idle_chk(1);
    @(negedge clk);
    req = 1; we = 0; addr = 32'h840; mem_ack = 0;
    #1;
    chk("mm_stall", stall, 1);
    @(negedge clk);
    #1;
    chk("mm_mem_en", mem_en, 1);
    chk("mm_mem_we", mem_we, 0);
    chk("mm_mem_addr", mem_addr, 32'h840);
    @(negedge clk);
    rst_n = 0; req = 0;
    @(negedge clk);
    #1;
    chk("mm_rst_mem_en", mem_en, 0);
    chk("mm_rst_stall", stall, 0);
    rst_n = 1; mem_ack = 1; mem_rdata = '1;
    @(negedge clk);
    mem_ack = 0;
    #1;
    chk("late_ack_mem_en", mem_en, 0);
    chk("late_ack_stall", stall, 0);
    model_reset();
`ifdef DCACHE_STATS_EN
    chk("mm_hit_cnt", hit_cnt, 0);
    chk("mm_miss_cnt", miss_cnt, 0);
`endif
    op("post_rst_840", 0, 32'h840, 0, 2);
    op("post_rst_44", 0, 32'h44, 0, 1);
    chk("post_rst_44_value", rd, 32'hDEADBEEF);
    for (int n = 0; n < 80; n++) begin
      ra = {1'($urandom_range(0, 1)), 19'd0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      op("rand", 1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) idle_chk(1);
    end
`ifdef DCACHE_STATS_EN
    chk("final_hit_cnt", hit_cnt, exp_hit);
    chk("final_miss_cnt", miss_cnt, exp_miss);
`endif
    idle_chk(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
